uart_rx: RTL
============

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have parameter OVERSAMPLE, default 16, giving the number of baud_clk cycles per UART bit (even, 8..32).
REQ-002 The block SHALL have port baud_clk  input  1  sample clock at OVERSAMPLE x bit rate; the only clock.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 The block SHALL have port rx_en  input  1  receiver enable; 0 forces IDLE.
REQ-005 The block SHALL have port n_parity  input  1  1 = no parity bit, 0 = parity bit present.
REQ-006 The block SHALL have port ev_parity  input  1  with n_parity=0: 1 = even parity, 0 = odd parity.
REQ-007 The block SHALL have port RXD  input  1  serial line, idle high, asynchronous to baud_clk.
REQ-008 The block SHALL have port rxd_out  output  8  last received data byte.
REQ-009 The block SHALL have port rx_ok  output  1  one-cycle pulse, frame complete.
REQ-010 The block SHALL have port parity_err  output  1  parity mismatch in the last frame.
REQ-011 The block SHALL have port frame_err  output  1  stop bit sampled low in the last frame.

Function
REQ-012 RXD SHALL pass through a 2-flop synchronizer preset to 1; all decisions SHALL use the synchronized value (rxs).
REQ-013 The FSM SHALL have states IDLE, START, DATA, PARITY and STOP, with a sample counter of width clog2(OVERSAMPLE) and a 3-bit bit index.
REQ-014 IDLE -> START SHALL occur on a 1->0 transition of rxs while rx_en=1; a line that stays low SHALL NOT retrigger.
REQ-015 START: at counter = OVERSAMPLE/2-1 (mid start bit), rxs=0 SHALL go to DATA with the counter cleared; rxs=1 SHALL be a false start and SHALL return to IDLE with no rx_ok.
REQ-016 DATA: each bit SHALL be sampled when the counter reaches OVERSAMPLE-1 (mid-bit), LSB first, into a shift register; after bit 7 the FSM SHALL go to PARITY if n_parity=0, else to STOP.
REQ-017 PARITY: the mid-bit sample SHALL be compared with ^data (even) or ~^data (odd); a mismatch SHALL set the internal parity flag.
REQ-018 STOP: at the mid-bit sample the block SHALL go to IDLE, and in that same transition it SHALL do all of the following: load rxd_out, load parity_err and frame_err (frame_err = ~rxs), and assert rx_ok for exactly one cycle.
REQ-019 rx_ok SHALL be asserted on the baud_clk edge that takes the stop-bit mid sample; rxd_out and the error flags SHALL be valid in the rx_ok cycle and SHALL hold until the next rx_ok.
REQ-020 When n_parity=1, parity_err SHALL be reported as 0.
REQ-021 Data SHALL be delivered even when parity_err or frame_err is set.
REQ-022 Returning to IDLE at mid stop bit SHALL allow a back-to-back frame to start with no idle gap.
REQ-023 n_parity and ev_parity SHALL be sampled when the FSM leaves START and held for the frame; changes mid-frame SHALL NOT affect the frame in flight.
REQ-024 rx_en=0 SHALL synchronously force IDLE, abort any partial frame (no rx_ok), and keep rxd_out and the error flags unchanged.

Reset
REQ-025 On rst_n=0 the block SHALL asynchronously set: state=IDLE, counters=0, shift register=0, synchronizer=1, rxd_out=8'h00, rx_ok=0, parity_err=0, frame_err=0.
REQ-026 A reset asserted mid-frame SHALL discard the frame; after release, reception SHALL resume only on a new falling edge.

Verification (OVERSAMPLE=16)
REQ-027 The bench SHALL cover: n_parity=1, frame 0,0xA5 LSB-first,1 -> one rx_ok pulse, rxd_out=8'hA5, parity_err=0, frame_err=0.
REQ-028 The bench SHALL cover: n_parity=0, ev_parity=1, byte 0x03 with parity bit 0, then the same byte with parity bit 1 -> parity_err=0, then parity_err=1, with rxd_out=8'h03 both times.
REQ-029 The bench SHALL cover: n_parity=0, ev_parity=0, byte 0x07 with parity bit 0 -> parity_err=0.
REQ-030 The bench SHALL cover: 0x3C sent with stop bit 0, then the line held low for 30 bit times -> one rx_ok, frame_err=1, rxd_out=8'h3C, and no further rx_ok until the line goes high and then falls again.
REQ-031 The bench SHALL cover: a 5-cycle low glitch on RXD -> no rx_ok, FSM back in IDLE; two back-to-back frames 0x55, 0xAA -> two rx_ok pulses, 160 +/- 8 cycles apart.
REQ-032 The bench SHALL cover: rst_n pulsed low in bit 4 of a frame -> all outputs take their reset values immediately; the next full frame 0x81 -> rxd_out=8'h81.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver, 8 data bits, optional parity.
// Each bit is sampled once, at its centre, by counting baud_clk cycles.
module uart_rx #(
   parameter int OVERSAMPLE = 16
) (
   input  logic       baud_clk,
   input  logic       rst_n,
   input  logic       rx_en,
   input  logic       n_parity,
   input  logic       ev_parity,
   input  logic       RXD,
   output logic [7:0] rxd_out,
   output logic       rx_ok,
   output logic       parity_err,
   output logic       frame_err
);

   localparam int CW = $clog2(OVERSAMPLE);
   localparam logic [CW-1:0] MID  = CW'(OVERSAMPLE / 2 - 1);
   localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_e;

   state_e        state_q, state_d;
   logic [1:0]    sync_q;
   logic          rxs;
   logic          rxs_prev_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          npar_q, npar_d;
   logic          evpar_q, evpar_d;
   logic          perr_q, perr_d;
   logic [7:0]    rxd_q, rxd_d;
   logic          rx_ok_q, rx_ok_d;
   logic          parity_err_q, parity_err_d;
   logic          frame_err_q, frame_err_d;
   logic          fall;
   logic          mid_start;
   logic          mid_bit;

   assign rxs       = sync_q[1];
   assign fall      = rxs_prev_q & ~rxs;
   assign mid_start = (cnt_q == MID);
   assign mid_bit   = (cnt_q == LAST);

   always_ff @(posedge baud_clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q       <= 2'b11;
         rxs_prev_q   <= 1'b1;
         state_q      <= IDLE;
         cnt_q        <= '0;
         bit_q        <= '0;
         shift_q      <= '0;
         npar_q       <= 1'b1;
         evpar_q      <= 1'b0;
         perr_q       <= 1'b0;
         rxd_q        <= '0;
         rx_ok_q      <= 1'b0;
         parity_err_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         sync_q       <= {sync_q[0], RXD};
         rxs_prev_q   <= rxs;
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         bit_q        <= bit_d;
         shift_q      <= shift_d;
         npar_q       <= npar_d;
         evpar_q      <= evpar_d;
         perr_q       <= perr_d;
         rxd_q        <= rxd_d;
         rx_ok_q      <= rx_ok_d;
         parity_err_q <= parity_err_d;
         frame_err_q  <= frame_err_d;
      end
   end

   // Only a 1->0 edge starts a frame, so a line stuck low never retriggers.
   always_comb begin
      state_d = state_q;
      if (!rx_en) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (fall) state_d = START;
            end
            START: begin
               if (mid_start) state_d = rxs ? IDLE : DATA;
            end
            DATA: begin
               if (mid_bit && bit_q == 3'd7)
                  state_d = npar_q ? STOP : PARITY;
            end
            PARITY: begin
               if (mid_bit) state_d = STOP;
            end
            STOP: begin
               if (mid_bit) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      cnt_d   = '0;
      bit_d   = bit_q;
      shift_d = shift_q;
      npar_d  = npar_q;
      evpar_d = evpar_q;
      perr_d  = perr_q;
      if (rx_en) begin
         unique case (state_q)
            START: begin
               cnt_d = cnt_q + 1'b1;
               if (mid_start) begin
                  cnt_d   = '0;
                  bit_d   = '0;
                  npar_d  = n_parity;
                  evpar_d = ev_parity;
                  perr_d  = 1'b0;
               end
            end
            DATA, PARITY, STOP: begin
               cnt_d = mid_bit ? '0 : cnt_q + 1'b1;
               if (state_q == DATA && mid_bit) begin
                  shift_d = {rxs, shift_q[7:1]};
                  bit_d   = bit_q + 1'b1;
               end
               if (state_q == PARITY && mid_bit)
                  perr_d = (rxs != (evpar_q ? ^shift_q : ~^shift_q));
            end
            default: cnt_d = '0;
         endcase
      end
   end

   // Results are loaded only when a frame completes; aborts leave them alone.
   always_comb begin
      rx_ok_d      = 1'b0;
      rxd_d        = rxd_q;
      parity_err_d = parity_err_q;
      frame_err_d  = frame_err_q;
      if (rx_en && state_q == STOP && mid_bit) begin
         rx_ok_d      = 1'b1;
         rxd_d        = shift_q;
         parity_err_d = ~npar_q & perr_q;
         frame_err_d  = ~rxs;
      end
   end

   assign rxd_out    = rxd_q;
   assign rx_ok      = rx_ok_q;
   assign parity_err = parity_err_q;
   assign frame_err  = frame_err_q;

endmodule
